// File: rtl/merger_scheduler.sv
// Feeds one fiber per lane into a radix-N merger tree, one merge request at a time.
// Optional perf counters are enabled with `define MERGER_SCHEDULER_PERF_EN.
module merger_scheduler #(
  parameter int COORD_BITS = 32,
  parameter int RADIX      = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [RADIX-1:0]            in_valid,
  input  logic [RADIX*COORD_BITS-1:0] in_coord,
  input  logic [RADIX-1:0]            in_last,
  output logic [RADIX-1:0]            in_ready,
  output logic [RADIX*COORD_BITS-1:0] m_coord_in,
  output logic                        m_selected,
  input  logic [COORD_BITS-1:0]       m_coord,
  input  logic [RADIX-1:0]            m_fetch_next,
  output logic                        out_valid,
  output logic [COORD_BITS-1:0]       out_coord,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
`ifdef MERGER_SCHEDULER_PERF_EN
  ,
  output logic [31:0]                 perf_cycles,
  output logic [31:0]                 perf_elems
`endif
);

  localparam logic [COORD_BITS-1:0] SENTINEL = '1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_CAPTURE, S_DONE} state_t;
  typedef enum logic [1:0] {H_EMPTY, H_VALID, H_EXHAUSTED} head_t;

  state_t                  state_q, state_d;
  head_t                   head_st_q [RADIX];
  head_t                   head_st_d [RADIX];
  logic [COORD_BITS-1:0]   head_coord_q [RADIX];
  logic [COORD_BITS-1:0]   head_coord_d [RADIX];
  logic [RADIX-1:0]        head_last_q, head_last_d;
  logic [COORD_BITS-1:0]   lane_in [RADIX];

  logic                    out_valid_q, out_valid_d;
  logic [COORD_BITS-1:0]   out_coord_q, out_coord_d;
  logic                    out_last_q, out_last_d;

  logic                    accepting;
  logic                    any_empty, any_valid, all_exh, fetch_hit;

  always_comb begin
    for (int i = 0; i < RADIX; i++) begin
      lane_in[i] = in_coord[i*COORD_BITS +: COORD_BITS];
      m_coord_in[i*COORD_BITS +: COORD_BITS] =
        (head_st_q[i] == H_VALID) ? head_coord_q[i] : SENTINEL;
    end
  end

  always_comb begin
    state_d      = state_q;
    head_st_d    = head_st_q;
    head_coord_d = head_coord_q;
    head_last_d  = head_last_q;
    out_valid_d  = out_valid_q;
    out_coord_d  = out_coord_q;
    out_last_d   = out_last_q;
    m_selected   = 1'b0;
    done         = 1'b0;
    in_ready     = '0;
    any_empty    = 1'b0;
    any_valid    = 1'b0;
    all_exh      = 1'b1;
    fetch_hit    = 1'b0;

    accepting = (state_q == S_FILL) || (state_q == S_ISSUE) || (state_q == S_CAPTURE);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // An all-ones beat marks an empty fiber: the lane retires without producing data.
    for (int i = 0; i < RADIX; i++) begin
      in_ready[i] = accepting && (head_st_q[i] == H_EMPTY);
      if (in_ready[i] && in_valid[i]) begin
        if (lane_in[i] == SENTINEL) begin
          head_st_d[i] = H_EXHAUSTED;
        end else begin
          head_st_d[i]    = H_VALID;
          head_coord_d[i] = lane_in[i];
          head_last_d[i]  = in_last[i];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          for (int i = 0; i < RADIX; i++) head_st_d[i] = H_EMPTY;
        end
      end
      // Decide on the post-acceptance head state so a beat taken here is usable at once.
      S_FILL: begin
        for (int i = 0; i < RADIX; i++) begin
          if (head_st_d[i] == H_EMPTY) any_empty = 1'b1;
          if (head_st_d[i] == H_VALID) any_valid = 1'b1;
        end
        if (!any_empty) state_d = any_valid ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        if (!out_valid_q) begin
          m_selected = 1'b1;
          state_d    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        for (int i = 0; i < RADIX; i++) begin
          if (m_fetch_next[i] && head_st_q[i] == H_VALID) begin
            fetch_hit    = 1'b1;
            head_st_d[i] = head_last_q[i] ? H_EXHAUSTED : H_EMPTY;
          end
        end
        for (int i = 0; i < RADIX; i++) begin
          if (head_st_d[i] != H_EXHAUSTED) all_exh = 1'b0;
        end
        if (fetch_hit && m_coord != SENTINEL) begin
          out_valid_d = 1'b1;
          out_coord_d = m_coord;
          out_last_d  = all_exh;
        end
        state_d = S_FILL;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_coord_q <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < RADIX; i++) head_st_q[i] <= H_EMPTY;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_coord_q <= out_coord_d;
      out_last_q  <= out_last_d;
      head_st_q   <= head_st_d;
    end
  end

  // Head payload is qualified by head state, so it needs no reset.
  always_ff @(posedge clock) begin
    head_coord_q <= head_coord_d;
    head_last_q  <= head_last_d;
  end

  assign out_valid = out_valid_q;
  assign out_coord = out_coord_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MERGER_SCHEDULER_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_elems_q, perf_elems_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_elems_d  = perf_elems_q;
    if (state_q == S_IDLE && start) begin
      perf_cycles_d = '0;
      perf_elems_d  = '0;
    end else begin
      if (busy) perf_cycles_d = sat_inc(perf_cycles_q);
      if (out_valid_q && out_ready) perf_elems_d = sat_inc(perf_elems_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_elems_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_elems_q  <= perf_elems_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_elems  = perf_elems_q;
`endif

endmodule

// File: tb/tb_merger_scheduler.sv
// Bench for merger_scheduler: directed merges plus randomized fibers against a sorted-union model.
module tb_merger_scheduler;
  localparam int CB = 32;
  localparam int R  = 2;
  localparam logic [CB-1:0] SENT = '1;

  logic              clock = 1'b0;
  logic              reset, start;
  logic [R-1:0]      in_valid, in_last, in_ready;
  logic [R*CB-1:0]   in_coord, m_coord_in;
  logic              m_selected;
  logic [CB-1:0]     m_coord;
  logic [R-1:0]      m_fetch_next;
  logic              out_valid, out_last, out_ready, busy, done;
  logic [CB-1:0]     out_coord;
`ifdef MERGER_SCHEDULER_PERF_EN
  logic [31:0]       perf_cycles, perf_elems;
`endif

  merger_scheduler #(.COORD_BITS(CB), .RADIX(R)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_coord(in_coord), .in_last(in_last), .in_ready(in_ready),
    .m_coord_in(m_coord_in), .m_selected(m_selected), .m_coord(m_coord),
    .m_fetch_next(m_fetch_next),
    .out_valid(out_valid), .out_coord(out_coord), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef MERGER_SCHEDULER_PERF_EN
    , .perf_cycles(perf_cycles), .perf_elems(perf_elems)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registered merger tree stand-in: returns the minimum head and fetches every lane holding it.
  bit stall_en;
  always @(posedge clock) begin : merger_model
    logic [CB-1:0] mn;
    logic [R-1:0]  f;
    mn = SENT;
    f  = '0;
    for (int i = 0; i < R; i++)
      if (m_coord_in[i*CB +: CB] < mn) mn = m_coord_in[i*CB +: CB];
    for (int i = 0; i < R; i++)
      if (m_coord_in[i*CB +: CB] == mn && mn != SENT) f[i] = 1'b1;
    if (reset) begin
      m_fetch_next <= '0;
      m_coord      <= '0;
    end else if (m_selected && !(stall_en && $urandom_range(0, 5) == 0)) begin
      m_coord      <= mn;
      m_fetch_next <= f;
    end else begin
      m_fetch_next <= '0;
    end
  end

  logic [CB:0] lane_q [R][$];

  task automatic push(input int l, input logic [CB-1:0] v, input logic last);
    lane_q[l].push_back({last, v});
  endtask

  task automatic load_basic();
    push(0, 1, 0); push(0, 4, 0); push(0, 7, 1);
    push(1, 2, 0); push(1, 3, 0); push(1, 9, 1);
  endtask

  task automatic check_reset_vals(input string name);
    check_eq({name, ".rst_in_ready"}, in_ready, 0);
    check_eq({name, ".rst_sel"}, m_selected, 0);
    check_eq({name, ".rst_out_valid"}, out_valid, 0);
    check_eq({name, ".rst_out_coord"}, out_coord, 0);
    check_eq({name, ".rst_out_last"}, out_last, 0);
    check_eq({name, ".rst_done"}, done, 0);
    check_eq({name, ".rst_busy"}, busy, 0);
    check_eq({name, ".rst_m_coord_in"}, m_coord_in, {(R*CB){1'b1}});
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_merge(input string name, input bit rnd, input int hold_first, input int reset_sel);
    logic [CB-1:0] all_q[$];
    logic [CB-1:0] exp_q[$];
    logic [CB:0]   hd;
    logic [R-1:0]  pop;
    logic [CB-1:0] prev_coord;
    logic          prev_last;
    bit            fin, prev_hold, do_reset, reset_now;
    int            k, sel_cnt, done_cnt, cyc, last_beat_cyc, prev_beat_cyc, stall_left;

    for (int l = 0; l < R; l++)
      foreach (lane_q[l][j]) begin
        hd = lane_q[l][j];
        if (hd[CB-1:0] != SENT) all_q.push_back(hd[CB-1:0]);
      end
    all_q.sort();
    foreach (all_q[i])
      if (exp_q.size() == 0 || exp_q[$] != all_q[i]) exp_q.push_back(all_q[i]);

    stall_en = rnd;
    k = 0; sel_cnt = 0; done_cnt = 0; cyc = 1; last_beat_cyc = 0; prev_beat_cyc = 0;
    stall_left = hold_first; fin = 0; prev_hold = 0; do_reset = 0; reset_now = 0;
    prev_coord = '0; prev_last = 0;

    #1 check_eq({name, ".idle_before"}, busy, 0);
    start = 1;
    @(posedge clock);
    @(negedge clock);
    start = 0;

    while (!fin && cyc < 2000) begin
      for (int l = 0; l < R; l++) begin
        in_valid[l] = 1'b0;
        in_coord[l*CB +: CB] = $urandom;
        in_last[l] = 1'($urandom_range(0, 1));
        if (lane_q[l].size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
          hd = lane_q[l][0];
          in_valid[l] = 1'b1;
          in_coord[l*CB +: CB] = hd[CB-1:0];
          in_last[l] = hd[CB];
        end
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (k == 0 && stall_left > 0) out_ready = 1'b0;
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (do_reset) begin
        reset = 1'b1;
        reset_now = 1;
        do_reset = 0;
      end
      #1;
      if (m_selected) begin
        check_eq({name, ".sel_out_clear"}, out_valid, 0);
        sel_cnt++;
      end
      if (prev_hold) begin
        check_eq({name, ".hold_valid"}, out_valid, 1);
        check_eq({name, ".hold_coord"}, out_coord, prev_coord);
        check_eq({name, ".hold_last"}, out_last, prev_last);
      end
      if (k == 0 && stall_left > 0 && out_valid) begin
        check_eq({name, ".stall_sel"}, m_selected, 0);
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (k < exp_q.size()) begin
          check_eq({name, ".coord"}, out_coord, exp_q[k]);
          check_eq({name, ".last"}, out_last, (k == exp_q.size() - 1));
          if (!rnd && hold_first == 0 && k > 0)
            check_eq({name, ".spacing"}, cyc - prev_beat_cyc, 3);
        end else begin
          check_eq({name, ".extra_beat"}, k, exp_q.size());
        end
        prev_beat_cyc = cyc;
        last_beat_cyc = cyc;
        k++;
      end
      prev_hold  = out_valid && !out_ready;
      prev_coord = out_coord;
      prev_last  = out_last;
      if (done) begin
        done_cnt++;
        check_eq({name, ".done_all"}, k, exp_q.size());
        check_eq({name, ".done_out"}, out_valid, 0);
        if (!rnd && hold_first == 0 && exp_q.size() > 0)
          check_eq({name, ".done_lat"}, cyc - last_beat_cyc, 1);
        fin = 1;
      end
      if (reset_sel > 0 && m_selected && sel_cnt == reset_sel) do_reset = 1;
      pop = in_valid & in_ready;
      @(posedge clock);
      for (int l = 0; l < R; l++)
        if (pop[l]) void'(lane_q[l].pop_front());
      @(negedge clock);
      cyc++;
      if (reset_now) begin
        reset = 1'b0;
        in_valid = '0;
        #1 check_reset_vals({name, ".abort"});
        fin = 1;
      end
    end

    in_valid = '0;
    start = 1'b0;
    check_eq({name, ".finished"}, fin, 1);
    if (!fin) begin
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
    end else if (!reset_now) begin
      check_eq({name, ".done_cnt"}, done_cnt, 1);
      #1 check_eq({name, ".idle_after"}, busy, 0);
`ifdef MERGER_SCHEDULER_PERF_EN
      check_eq({name, ".perf_elems"}, perf_elems, exp_q.size());
`endif
    end
    for (int l = 0; l < R; l++) lane_q[l].delete();
    @(negedge clock);
  endtask

  initial begin
    int n;
    logic [CB-1:0] v;
    reset = 1'b1; start = 1'b0; in_valid = '0; in_coord = '0; in_last = '0;
    out_ready = 1'b0; stall_en = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 check_reset_vals("init");
    reset = 1'b0;
    @(negedge clock);

    load_basic();
    run_merge("basic", 0, 0, 0);

    push(0, 5, 1);
    push(1, SENT, 1);
    run_merge("sentinel", 0, 0, 0);

    push(0, SENT, 1);
    push(1, SENT, 1);
    run_merge("empty", 0, 0, 0);

    load_basic();
    run_merge("backpressure", 0, 5, 0);

    load_basic();
    run_merge("abort", 0, 0, 3);

    load_basic();
    run_merge("after_abort", 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int l = 0; l < R; l++) begin
        n = $urandom_range(0, 5);
        if (n == 0) begin
          push(l, SENT, 1);
        end else begin
          v = '0;
          for (int j = 0; j < n; j++) begin
            v = v + CB'($urandom_range(1, 6));
            push(l, v, (j == n - 1));
          end
        end
      end
      run_merge("random", 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/merger_scheduler.md
MERGER_SCHEDULER -- requirements
Module: merger_scheduler

Interface
REQ-001 Parameter COORD_BITS, default 32, width of one coordinate.
REQ-002 Parameter RADIX, default 2, number of input lanes (power of two, >=2); equals radix of the attached merger tree.
REQ-003 clock  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a merge of one fiber per lane; sampled only in IDLE.
REQ-006 in_valid  input  RADIX  per-lane coordinate beat valid.
REQ-007 in_coord  input  RADIX*COORD_BITS  per-lane coordinate; lane i at bits [i*COORD_BITS +: COORD_BITS].
REQ-008 in_last  input  RADIX  per-lane: beat is last of that lane's fiber.
REQ-009 in_ready  output  RADIX  per-lane: head register accepts a beat this cycle.
REQ-010 m_coord_in  output  RADIX*COORD_BITS  lane heads driven to merger coord_in.
REQ-011 m_selected  output  1  one-cycle merge request to merger selected.
REQ-012 m_coord  input  COORD_BITS  merger registered output coordinate.
REQ-013 m_fetch_next  input  RADIX  merger registered per-lane consume indication.
REQ-014 out_valid / out_coord / out_last  output  1 / COORD_BITS / 1  merged stream; out_last marks final element.
REQ-015 out_ready  input  1  downstream accepts out beat.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse at merge completion.

Function
REQ-018 SENTINEL = all-ones COORD_BITS; reserved, never emitted on out_coord.
REQ-019 Per-lane head state: EMPTY, VALID, EXHAUSTED; m_coord_in lane i = head coord if VALID, SENTINEL otherwise.
REQ-020 in_ready[i] = 1 iff head[i] EMPTY and state in {FILL, ISSUE, CAPTURE}; beat taken on in_valid[i] & in_ready[i].
REQ-021 Accepted beat with coord != SENTINEL: head VALID, stores coord and in_last.
REQ-022 Accepted beat with coord == SENTINEL (empty fiber): head EXHAUSTED directly, nothing emitted.
REQ-023 FSM states IDLE, FILL, ISSUE, CAPTURE, DONE.
REQ-024 IDLE: start=1 -> FILL, all heads set EMPTY.
REQ-025 FILL: when no head EMPTY -> ISSUE if any head VALID, else DONE.
REQ-026 ISSUE: if out_valid=0, assert m_selected for exactly one cycle -> CAPTURE; else hold.
REQ-027 CAPTURE (one cycle after m_selected): load out_coord<=m_coord, out_valid<=1; every lane with m_fetch_next[i]=1 and head VALID becomes EXHAUSTED if stored last=1, else EMPTY; fetch_next bits on non-VALID lanes ignored; -> FILL.
REQ-028 out_last=1 iff, after the CAPTURE update, every head is EXHAUSTED.
REQ-029 out_valid clears on out_valid & out_ready; out_coord/out_last stable while out_valid & !out_ready.
REQ-030 DONE: done=1 for one cycle, wait for out_valid=0 first if pending, then -> IDLE.
REQ-031 Throughput: max one element per 3 cycles (FILL, ISSUE, CAPTURE) with all lanes pre-valid.
REQ-032 m_fetch_next all-zero in CAPTURE: no head changes, no out beat produced, -> FILL.
REQ-033 start while busy=1 ignored.

Reset
REQ-034 reset forces state IDLE, all heads EMPTY, in_ready=0, m_selected=0, out_valid=0, out_coord=0, out_last=0, done=0, busy=0, m_coord_in=all SENTINEL.
REQ-035 reset mid-merge aborts immediately; no done pulse; partially accepted lane beats discarded.

Configuration
REQ-036 Macro MERGER_SCHEDULER_PERF_EN defined: adds outputs perf_cycles (32 bits, counts cycles with busy=1) and perf_elems (32 bits, counts out beats accepted); both clear on reset and on start in IDLE, saturate at all-ones.
REQ-037 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-038 RADIX=2, lane0 {1,4,7L}, lane1 {2,3,9L}, out_ready=1 -> out 1,2,3,4,7,9; out_last only on 9; done one cycle after 9 drains.
REQ-039 lane0 {5L}, lane1 single SENTINEL beat with last -> out 5 with out_last=1; SENTINEL never emitted.
REQ-040 Both lanes SENTINEL-only -> no out beats; done pulses; return to IDLE.
REQ-041 out_ready=0 for 5 cycles after first beat -> out_coord held, m_selected stays 0 throughout, merge resumes afterward.
REQ-042 reset asserted in CAPTURE of third element -> next cycle all outputs at reset values, no done; a new start produces a correct full merge.
REQ-043 PERF_EN build, REQ-038 stimulus -> perf_elems=6 at done.
